// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller for the RV32I pipeline.
// Handles CSR access, illegal/interrupt traps, mret and the 64-bit cycle counter.
module csr_trap_unit #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic        stall,
    input  logic [31:0] pc,
    input  logic        csr_we,
    input  logic        csr_wdata_sel,
    input  logic [1:0]  csr_wdata_op,
    input  logic        csr_src_zero,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  zimm,
    input  logic        invalid_instruction,
    input  logic        is_mret,
    input  logic        irq_ext,
    input  logic        irq_timer,
    output logic [31:0] csr_rdata,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;

    logic                   st_mie_q, st_mie_d;
    logic                   st_mpie_q, st_mpie_d;
    logic                   ie_mtie_q, ie_mtie_d;
    logic                   ie_meie_q, ie_meie_d;
    logic [31:0]            mtvec_q, mtvec_d;
    logic [31:0]            mscratch_q, mscratch_d;
    logic [31:0]            mepc_q, mepc_d;
    logic [31:0]            mcause_q, mcause_d;
    logic [63:0]            mcycle_q, mcycle_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    logic        meip_s;
    logic        exc;
    logic        ext_pend;
    logic        tmr_pend;
    logic        int_pend;
    logic        take_trap;
    logic        do_mret;
    logic        we_eff;
    logic [31:0] src;
    logic [31:0] wnew;

    assign meip_s   = sync_q[SYNC_STAGES-1];
    assign exc      = instr_valid & invalid_instruction;
    assign ext_pend = ie_meie_q & meip_s;
    assign tmr_pend = ie_mtie_q & irq_timer;
    assign int_pend = instr_valid & st_mie_q & (ext_pend | tmr_pend);
    assign take_trap = !stall & (exc | int_pend);
    assign do_mret   = !stall & instr_valid & is_mret & !exc & !int_pend;

    // Set/clear with a zero source and the reserved op never write.
    assign we_eff = instr_valid & csr_we & !stall & !take_trap
                  & !((csr_wdata_op != 2'd0) & csr_src_zero)
                  & (csr_wdata_op != 2'd3);

    assign redirect    = rst_n & (take_trap | do_mret);
    assign flush       = redirect;
    assign redirect_pc = take_trap ? mtvec_q : mepc_q;

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            A_MSTATUS:  csr_rdata = {24'h0, st_mpie_q, 3'b0, st_mie_q, 3'b0};
            A_MIE:      csr_rdata = {20'h0, ie_meie_q, 3'b0, ie_mtie_q, 7'b0};
            A_MTVEC:    csr_rdata = mtvec_q;
            A_MSCRATCH: csr_rdata = mscratch_q;
            A_MEPC:     csr_rdata = mepc_q;
            A_MCAUSE:   csr_rdata = mcause_q;
            A_MIP:      csr_rdata = {20'h0, meip_s, 3'b0, irq_timer, 7'b0};
            A_MCYCLE:   csr_rdata = mcycle_q[31:0];
            A_MCYCLEH:  csr_rdata = mcycle_q[63:32];
            default:    csr_rdata = 32'h0;
        endcase
    end

    always_comb begin
        src  = csr_wdata_sel ? {27'h0, zimm} : rs1_data;
        wnew = csr_rdata;
        case (csr_wdata_op)
            2'd0:    wnew = src;
            2'd1:    wnew = csr_rdata | src;
            2'd2:    wnew = csr_rdata & ~src;
            default: wnew = csr_rdata;
        endcase
    end

    always_comb begin
        st_mie_d   = st_mie_q;
        st_mpie_d  = st_mpie_q;
        ie_mtie_d  = ie_mtie_q;
        ie_meie_d  = ie_meie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = mcycle_q + 64'd1;
        sync_d     = {sync_q[SYNC_STAGES-2:0], irq_ext};
        if (we_eff) begin
            case (csr_addr)
                A_MSTATUS: begin
                    st_mie_d  = wnew[3];
                    st_mpie_d = wnew[7];
                end
                A_MIE: begin
                    ie_mtie_d = wnew[7];
                    ie_meie_d = wnew[11];
                end
                A_MTVEC:    mtvec_d    = wnew & 32'hFFFF_FFFC;
                A_MSCRATCH: mscratch_d = wnew;
                A_MEPC:     mepc_d     = wnew & 32'hFFFF_FFFC;
                A_MCAUSE:   mcause_d   = wnew;
                A_MCYCLE:   mcycle_d   = {mcycle_q[63:32], wnew};
                A_MCYCLEH:  mcycle_d   = {wnew, mcycle_q[31:0]};
                default: ;
            endcase
        end
        if (take_trap) begin
            mepc_d    = pc & 32'hFFFF_FFFC;
            mcause_d  = exc      ? 32'd2 :
                        ext_pend ? 32'h8000_000B : 32'h8000_0007;
            st_mpie_d = st_mie_q;
            st_mie_d  = 1'b0;
        end else if (do_mret) begin
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            ie_mtie_q  <= 1'b0;
            ie_meie_q  <= 1'b0;
            mtvec_q    <= RESET_MTVEC & 32'hFFFF_FFFC;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            mcycle_q   <= 64'h0;
            sync_q     <= '0;
        end else begin
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            ie_mtie_q  <= ie_mtie_d;
            ie_meie_q  <= ie_meie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            sync_q     <= sync_d;
        end
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed self-checking bench for csr_trap_unit.
// Each task drives one scenario and checks results against hand-computed values.
`timescale 1ns/1ps
module tb_csr_trap_unit;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        stall;
    logic [31:0] pc;
    logic        csr_we;
    logic        csr_wdata_sel;
    logic [1:0]  csr_wdata_op;
    logic        csr_src_zero;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data;
    logic [4:0]  zimm;
    logic        invalid_instruction;
    logic        is_mret;
    logic        irq_ext;
    logic        irq_timer;
    logic [31:0] csr_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;

    int checks;
    int failures;
    logic [31:0] v;

    csr_trap_unit #(
        .RESET_MTVEC(32'h0000_0103),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .stall(stall),
        .pc(pc), .csr_we(csr_we), .csr_wdata_sel(csr_wdata_sel),
        .csr_wdata_op(csr_wdata_op), .csr_src_zero(csr_src_zero),
        .csr_addr(csr_addr), .rs1_data(rs1_data), .zimm(zimm),
        .invalid_instruction(invalid_instruction), .is_mret(is_mret),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .csr_rdata(csr_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr_valid = 0; stall = 0; csr_we = 0; csr_wdata_sel = 0;
        csr_wdata_op = 0; csr_src_zero = 0; invalid_instruction = 0;
        is_mret = 0; rs1_data = 0; zimm = 0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] r);
        idle();
        csr_addr = a;
        #0.1;
        r = csr_rdata;
    endtask

    task automatic csr_instr(input logic [11:0] a, input logic [1:0] op,
                             input logic sel, input logic [31:0] rs1,
                             input logic [4:0] z, input logic sz);
        idle();
        instr_valid = 1; csr_we = 1; csr_addr = a; csr_wdata_op = op;
        csr_wdata_sel = sel; rs1_data = rs1; zimm = z; csr_src_zero = sz;
        #0.1;
    endtask

    task automatic test_reset();
        rst_n = 0; idle(); irq_ext = 0; irq_timer = 0; pc = 0; csr_addr = 0;
        step();
        instr_valid = 1; invalid_instruction = 1;
        #0.1;
        checks++; if (redirect !== 1'b0 || flush !== 1'b0) begin
            failures++; $display("FAIL reset_redirect got=%b/%b exp=0/0", redirect, flush); end
        step();
        rst_n = 1;
        rd(12'h305, v);
        checks++; if (v !== 32'h0000_0100) begin
            failures++; $display("FAIL reset_mtvec got=%h exp=00000100", v); end
        rd(12'h300, v);
        checks++; if (v !== 32'h0) begin
            failures++; $display("FAIL reset_mstatus got=%h exp=0", v); end
        rd(12'hB00, v);
        checks++; if (v !== 32'h0) begin
            failures++; $display("FAIL reset_mcycle got=%h exp=0", v); end
    endtask

    task automatic test_write_set();
        csr_instr(12'h305, 2'd0, 0, 32'h0000_1003, 0, 0);
        checks++; if (csr_rdata !== 32'h0000_0100) begin
            failures++; $display("FAIL wr_mtvec_old got=%h exp=00000100", csr_rdata); end
        step();
        csr_instr(12'h340, 2'd0, 0, 32'h10, 0, 0);
        step();
        csr_instr(12'h340, 2'd1, 1, 32'hFFFF_0000, 5'd5, 0);
        checks++; if (csr_rdata !== 32'h10) begin
            failures++; $display("FAIL set_old got=%h exp=00000010", csr_rdata); end
        step();
        csr_instr(12'h340, 2'd3, 0, 32'hFFFF_FFFF, 0, 0);
        step();
        csr_instr(12'h7C0, 2'd0, 0, 32'h1234_5678, 0, 0);
        step();
        rd(12'h305, v);
        checks++; if (v !== 32'h0000_1000) begin
            failures++; $display("FAIL mtvec got=%h exp=00001000", v); end
        rd(12'h340, v);
        checks++; if (v !== 32'h15) begin
            failures++; $display("FAIL mscratch got=%h exp=00000015", v); end
        rd(12'h7C0, v);
        checks++; if (v !== 32'h0) begin
            failures++; $display("FAIL unimpl got=%h exp=0", v); end
    endtask

    task automatic test_clear_zero();
        csr_instr(12'h300, 2'd0, 0, 32'hFFFF_FFFF, 0, 0);
        step();
        rd(12'h300, v);
        checks++; if (v !== 32'h88) begin
            failures++; $display("FAIL mstatus_mask got=%h exp=00000088", v); end
        csr_instr(12'h300, 2'd0, 0, 32'h8, 0, 0);
        step();
        csr_instr(12'h300, 2'd2, 0, 32'h8, 0, 1);
        checks++; if (csr_rdata !== 32'h8) begin
            failures++; $display("FAIL clr_old got=%h exp=00000008", csr_rdata); end
        step();
        rd(12'h300, v);
        checks++; if (v !== 32'h8) begin
            failures++; $display("FAIL clr_zero got=%h exp=00000008", v); end
    endtask

    task automatic test_illegal();
        csr_instr(12'h305, 2'd0, 0, 32'h200, 0, 0);
        step();
        idle(); instr_valid = 1; invalid_instruction = 1; pc = 32'h104;
        #0.1;
        checks++; if (redirect !== 1 || flush !== 1 || redirect_pc !== 32'h200) begin
            failures++; $display("FAIL ill_redirect got=%b/%b/%h exp=1/1/00000200",
                                 redirect, flush, redirect_pc); end
        step();
        idle();
        #0.1;
        checks++; if (redirect !== 1'b0) begin
            failures++; $display("FAIL ill_pulse got=%b exp=0", redirect); end
        rd(12'h341, v);
        checks++; if (v !== 32'h104) begin
            failures++; $display("FAIL ill_mepc got=%h exp=00000104", v); end
        rd(12'h342, v);
        checks++; if (v !== 32'd2) begin
            failures++; $display("FAIL ill_mcause got=%h exp=00000002", v); end
        rd(12'h300, v);
        checks++; if (v !== 32'h80) begin
            failures++; $display("FAIL ill_mstatus got=%h exp=00000080", v); end
    endtask

    task automatic test_ext_irq();
        csr_instr(12'h304, 2'd0, 0, 32'h800, 0, 0);
        step();
        csr_instr(12'h300, 2'd0, 0, 32'h8, 0, 0);
        step();
        irq_ext = 1;
        step();
        rd(12'h344, v);
        checks++; if (v !== 32'h0) begin
            failures++; $display("FAIL sync_early got=%h exp=0", v); end
        step();
        rd(12'h344, v);
        checks++; if (v !== 32'h800) begin
            failures++; $display("FAIL sync_pend got=%h exp=00000800", v); end
        idle(); instr_valid = 1; pc = 32'h40;
        #0.1;
        checks++; if (redirect !== 1 || redirect_pc !== 32'h200) begin
            failures++; $display("FAIL ext_redirect got=%b/%h exp=1/00000200",
                                 redirect, redirect_pc); end
        step();
        irq_ext = 0;
        rd(12'h342, v);
        checks++; if (v !== 32'h8000_000B) begin
            failures++; $display("FAIL ext_mcause got=%h exp=8000000b", v); end
        rd(12'h341, v);
        checks++; if (v !== 32'h40) begin
            failures++; $display("FAIL ext_mepc got=%h exp=00000040", v); end
        step(); step(); step();
        idle(); instr_valid = 1; is_mret = 1; pc = 32'h200;
        #0.1;
        checks++; if (redirect !== 1 || redirect_pc !== 32'h40) begin
            failures++; $display("FAIL mret_redirect got=%b/%h exp=1/00000040",
                                 redirect, redirect_pc); end
        step();
        rd(12'h300, v);
        checks++; if (v !== 32'h88) begin
            failures++; $display("FAIL mret_mstatus got=%h exp=00000088", v); end
    endtask

    task automatic test_simultaneous();
        csr_instr(12'h304, 2'd0, 0, 32'h80, 0, 0);
        step();
        irq_timer = 1;
        idle(); instr_valid = 1; invalid_instruction = 1; csr_we = 1;
        csr_addr = 12'h340; rs1_data = 32'hDEAD; pc = 32'h300; stall = 1;
        for (int i = 0; i < 3; i++) begin
            #0.1;
            checks++; if (redirect !== 1'b0 || csr_rdata !== 32'h15) begin
                failures++; $display("FAIL stall_%0d got=%b/%h exp=0/00000015",
                                     i, redirect, csr_rdata); end
            step();
        end
        stall = 0;
        #0.1;
        checks++; if (redirect !== 1 || redirect_pc !== 32'h200) begin
            failures++; $display("FAIL sim_redirect got=%b/%h exp=1/00000200",
                                 redirect, redirect_pc); end
        step();
        rd(12'h342, v);
        checks++; if (v !== 32'd2) begin
            failures++; $display("FAIL sim_mcause got=%h exp=00000002", v); end
        rd(12'h340, v);
        checks++; if (v !== 32'h15) begin
            failures++; $display("FAIL sim_nowrite got=%h exp=00000015", v); end
        csr_instr(12'h300, 2'd0, 0, 32'h8, 0, 0);
        step();
        idle(); instr_valid = 1; pc = 32'h56;
        step();
        irq_timer = 0;
        rd(12'h342, v);
        checks++; if (v !== 32'h8000_0007) begin
            failures++; $display("FAIL tmr_mcause got=%h exp=80000007", v); end
        rd(12'h341, v);
        checks++; if (v !== 32'h54) begin
            failures++; $display("FAIL tmr_mepc got=%h exp=00000054", v); end
    endtask

    task automatic test_counter();
        csr_instr(12'hB00, 2'd0, 0, 32'hFFFF_FFFF, 0, 0);
        step();
        csr_instr(12'hB80, 2'd0, 0, 32'hFFFF_FFFF, 0, 0);
        step();
        rd(12'hB00, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL cyc_lo_max got=%h exp=ffffffff", v); end
        rd(12'hB80, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL cyc_hi_max got=%h exp=ffffffff", v); end
        step();
        rd(12'hB00, v);
        checks++; if (v !== 32'h0) begin
            failures++; $display("FAIL cyc_lo_wrap got=%h exp=0", v); end
        rd(12'hB80, v);
        checks++; if (v !== 32'h0) begin
            failures++; $display("FAIL cyc_hi_wrap got=%h exp=0", v); end
        step(); step(); step();
        rd(12'hB00, v);
        checks++; if (v !== 32'h3) begin
            failures++; $display("FAIL cyc_count got=%h exp=00000003", v); end
        rst_n = 0;
        idle(); instr_valid = 1; invalid_instruction = 1; pc = 32'h80;
        step();
        rst_n = 1;
        rd(12'hB00, v);
        checks++; if (v !== 32'h0) begin
            failures++; $display("FAIL rst_mcycle got=%h exp=0", v); end
        rd(12'h305, v);
        checks++; if (v !== 32'h100) begin
            failures++; $display("FAIL rst_mtvec got=%h exp=00000100", v); end
        rd(12'h341, v);
        checks++; if (v !== 32'h0) begin
            failures++; $display("FAIL rst_mepc got=%h exp=0", v); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_write_set();
        test_clear_zero();
        test_illegal();
        test_ext_irq();
        test_simultaneous();
        test_counter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
